// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cdb_arbiter
// Description : Round-robin arbiter for add/mul/load results onto a registered
//               common data bus.
// Revision    : 1.0 - initial release
// ============================================================================
module cdb_arbiter #(
  parameter int TAG_W  = 4,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              add_req,
  input  logic              mul_req,
  input  logic              load_req,
  input  logic [TAG_W-1:0]  add_tag,
  input  logic [TAG_W-1:0]  mul_tag,
  input  logic [TAG_W-1:0]  load_tag,
  input  logic [DATA_W-1:0] add_value,
  input  logic [DATA_W-1:0] mul_value,
  input  logic [DATA_W-1:0] load_value,
  output logic              add_grant,
  output logic              mul_grant,
  output logic              load_grant,
  output logic              cdb_valid,
  output logic [TAG_W-1:0]  cdb_tag,
  output logic [DATA_W-1:0] cdb_value,
  output logic [1:0]        cdb_src
);

  localparam logic [1:0] c_SRC_ADD  = 2'd0;
  localparam logic [1:0] c_SRC_MUL  = 2'd1;
  localparam logic [1:0] c_SRC_LOAD = 2'd2;

  logic [1:0]        r_ptr;
  logic [2:0]        w_req;
  logic [2:0]        w_grant;
  logic              w_found;
  logic [1:0]        w_idx;
  logic [1:0]        w_ptr_next;
  logic [TAG_W-1:0]  w_tag;
  logic [DATA_W-1:0] w_value;

  // Modulo-3 add; both operands are always in 0..2 so one correction suffices.
  function automatic logic [1:0] wrap3(input logic [1:0] a, input logic [1:0] b);
    logic [2:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= 3'd3) s = s - 3'd3;
    return s[1:0];
  endfunction

  always_comb begin
    w_req   = {load_req, mul_req, add_req} & {3{~(rst | flush)}};
    w_found = 1'b0;
    w_idx   = c_SRC_ADD;
    for (int k = 0; k < 3; k++) begin
      if (!w_found && w_req[wrap3(r_ptr, k[1:0])]) begin
        w_found = 1'b1;
        w_idx   = wrap3(r_ptr, k[1:0]);
      end
    end
    w_grant    = w_found ? (3'b001 << w_idx) : 3'b000;
    w_ptr_next = wrap3(w_idx, 2'd1);
  end

  always_comb begin
    w_tag   = add_tag;
    w_value = add_value;
    case (w_idx)
      c_SRC_MUL: begin
        w_tag   = mul_tag;
        w_value = mul_value;
      end
      c_SRC_LOAD: begin
        w_tag   = load_tag;
        w_value = load_value;
      end
      default: begin
        w_tag   = add_tag;
        w_value = add_value;
      end
    endcase
  end

  assign add_grant  = w_grant[0];
  assign mul_grant  = w_grant[1];
  assign load_grant = w_grant[2];

  // Payload registers hold their last value when nothing is granted.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr     <= c_SRC_ADD;
      cdb_valid <= 1'b0;
      cdb_tag   <= '0;
      cdb_value <= '0;
      cdb_src   <= c_SRC_ADD;
    end else begin
      cdb_valid <= w_found;
      if (w_found) begin
        r_ptr     <= w_ptr_next;
        cdb_tag   <= w_tag;
        cdb_value <= w_value;
        cdb_src   <= w_idx;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cdb_arbiter
// Description : Directed self-checking bench for cdb_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cdb_arbiter;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic        add_req, mul_req, load_req;
  logic [3:0]  add_tag, mul_tag, load_tag;
  logic [31:0] add_value, mul_value, load_value;
  logic        add_grant, mul_grant, load_grant;
  logic        cdb_valid;
  logic [3:0]  cdb_tag;
  logic [31:0] cdb_value;
  logic [1:0]  cdb_src;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  cdb_arbiter #(.TAG_W(4), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .add_req(add_req), .mul_req(mul_req), .load_req(load_req),
    .add_tag(add_tag), .mul_tag(mul_tag), .load_tag(load_tag),
    .add_value(add_value), .mul_value(mul_value), .load_value(load_value),
    .add_grant(add_grant), .mul_grant(mul_grant), .load_grant(load_grant),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .cdb_src(cdb_src)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Expected grant vector is {load, mul, add}.
  task automatic chk_grant(input string tag, input logic [2:0] exp);
    chk({tag, ".grant"}, {61'd0, load_grant, mul_grant, add_grant}, {61'd0, exp});
  endtask

  task automatic chk_cdb(input string tag, input logic v, input logic [3:0] t,
                         input logic [31:0] val, input logic [1:0] s);
    chk({tag, ".valid"}, {63'd0, cdb_valid}, {63'd0, v});
    chk({tag, ".tag"},   {60'd0, cdb_tag},   {60'd0, t});
    chk({tag, ".value"}, {32'd0, cdb_value}, {32'd0, val});
    chk({tag, ".src"},   {62'd0, cdb_src},   {62'd0, s});
  endtask

  // Advance to just after the next rising edge; registered outputs are stable.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic a, input logic m, input logic l);
    add_req  = a;
    mul_req  = m;
    load_req = l;
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0;
    add_req = 1'b0; mul_req = 1'b0; load_req = 1'b0;
    add_tag = 4'd1; mul_tag = 4'd2; load_tag = 4'd3;
    add_value = 32'h11; mul_value = 32'h22; load_value = 32'h33;

    // Reset state, with requests present to confirm grants are gated
    tick;
    set_req(1, 1, 1);
    chk_grant("rst_gate", 3'b000);
    tick;
    chk_cdb("rst_state", 1'b0, 4'd0, 32'd0, 2'd0);

    // Round-robin with all three requesting
    rst = 1'b0;
    #1;
    chk_grant("rr_c1", 3'b001);
    tick;
    chk_cdb("rr_b1", 1'b1, 4'd1, 32'h11, 2'd0);
    chk_grant("rr_c2", 3'b010);
    tick;
    chk_cdb("rr_b2", 1'b1, 4'd2, 32'h22, 2'd1);
    chk_grant("rr_c3", 3'b100);
    tick;
    chk_cdb("rr_b3", 1'b1, 4'd3, 32'h33, 2'd2);
    chk_grant("rr_wrap", 3'b001);
    tick;                                   // ptr -> 1

    // Sole mul requester, then granted again back-to-back
    mul_tag = 4'd5; mul_value = 32'h000000AB;
    set_req(0, 1, 0);
    chk_grant("mul_only", 3'b010);
    tick;
    chk_cdb("mul_b", 1'b1, 4'd5, 32'hAB, 2'd1);
    chk_grant("mul_again", 3'b010);
    tick;                                   // ptr -> 2
    chk_cdb("mul_b2", 1'b1, 4'd5, 32'hAB, 2'd1);

    // add and load alternate, mul idle (pointer at 2 so load goes first)
    set_req(1, 0, 1);
    chk_grant("al_1", 3'b100);
    tick;
    chk_cdb("al_b1", 1'b1, 4'd3, 32'h33, 2'd2);
    chk_grant("al_2", 3'b001);
    tick;
    chk_cdb("al_b2", 1'b1, 4'd1, 32'h11, 2'd0);
    chk_grant("al_3", 3'b100);
    tick;
    chk_grant("al_4", 3'b001);
    tick;                                   // ptr -> 1, cdb holds add tag 1

    // Flush for two cycles with everyone requesting
    mul_tag = 4'd2; mul_value = 32'h22;
    flush = 1'b1;
    set_req(1, 1, 1);
    chk_grant("fl_1", 3'b000);
    chk("fl_keep_bcast", {63'd0, cdb_valid}, 64'd1);
    tick;
    chk_cdb("fl_b1", 1'b0, 4'd1, 32'h11, 2'd0);
    chk_grant("fl_2", 3'b000);
    tick;
    chk("fl_b2.valid", {63'd0, cdb_valid}, 64'd0);
    flush = 1'b0;
    #1;
    chk_grant("fl_resume", 3'b010);
    tick;                                   // ptr -> 2
    chk_cdb("fl_rb", 1'b1, 4'd2, 32'h22, 2'd1);

    // Idle cycle after a tag-4 broadcast
    add_tag = 4'd4; add_value = 32'h44;
    set_req(1, 0, 0);
    chk_grant("t4", 3'b001);
    tick;                                   // ptr -> 1
    chk_cdb("t4_b", 1'b1, 4'd4, 32'h44, 2'd0);
    set_req(0, 0, 0);
    chk_grant("idle", 3'b000);
    tick;
    chk_cdb("idle_b", 1'b0, 4'd4, 32'h44, 2'd0);

    // Reset mid-stream with pointer at 2
    set_req(0, 1, 0);
    chk_grant("pre_rst", 3'b010);
    tick;                                   // ptr -> 2
    rst = 1'b1;
    set_req(1, 1, 1);
    chk_grant("rst_mid", 3'b000);
    tick;
    chk_cdb("rst_mid_b", 1'b0, 4'd0, 32'd0, 2'd0);
    rst = 1'b0;
    #1;
    chk_grant("post_rst", 3'b001);
    tick;
    chk_cdb("post_rst_b", 1'b1, 4'd4, 32'h44, 2'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL have parameter TAG_W, default 4, width of the reservation-station tag.
REQ-002 SHALL have parameter DATA_W, default 32, width of the broadcast result value.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port flush  input  1  drop all requests this cycle (mispredict/squash).
REQ-006 SHALL have ports add_req / mul_req / load_req  input  1 each  unit holds a completed result.
REQ-007 SHALL have ports add_tag / mul_tag / load_tag  input  TAG_W each  producing RS tag.
REQ-008 SHALL have ports add_value / mul_value / load_value  input  DATA_W each  result value.
REQ-009 SHALL have ports add_grant / mul_grant / load_grant  output  1 each  payload accepted this edge.
REQ-010 SHALL have port cdb_valid  output  1  broadcast valid on the common data bus.
REQ-011 SHALL have port cdb_tag  output  TAG_W  broadcast tag.
REQ-012 SHALL have port cdb_value  output  DATA_W  broadcast value.
REQ-013 SHALL have port cdb_src  output  2  source of broadcast: 0 add, 1 mul, 2 load.

Function
REQ-014 SHALL assert at most one grant per cycle; grants are combinational from req, flush, rst and the priority pointer.
REQ-015 SHALL treat a grant as the handshake: payload captured at the same rising edge; requester holds req, tag, value stable until granted.
REQ-016 SHALL arbitrate round-robin over order add(0), mul(1), load(2), starting the search at the 2-bit priority pointer.
REQ-017 SHALL set the pointer to (granted index + 1) mod 3 after a grant; pointer unchanged when no grant.
REQ-018 SHALL never let the pointer hold value 3.
REQ-019 SHALL register the broadcast: one edge after a grant, cdb_valid=1 with cdb_tag, cdb_value, cdb_src of the granted unit (latency 1 cycle).
REQ-020 SHALL drive cdb_valid=0 in any cycle following a cycle with no grant; cdb_tag, cdb_value, cdb_src hold their previous values.
REQ-021 SHALL, while flush=1, force all grants to 0, leave the pointer unchanged, and make cdb_valid=0 on the next cycle.
REQ-022 SHALL NOT cancel a broadcast already registered when flush rises; only the capture in the flush cycle is suppressed.
REQ-023 SHALL guarantee a continuously requesting unit is granted within 3 consecutive non-flush cycles.
REQ-024 SHALL permit the same unit to be granted on consecutive cycles when it is the sole requester.

Reset
REQ-025 SHALL, while rst=1, force all grants to 0 in that cycle.
REQ-026 SHALL, at the edge where rst=1, set pointer=0, cdb_valid=0, cdb_tag=0, cdb_value=0, cdb_src=0.
REQ-027 SHALL give rst priority over flush and all requests, including reset asserted mid-stream.

Verification
REQ-028 SHALL cover: after reset, add/mul/load request continuously (tags 1,2,3) -> grants add,mul,load in cycles 1,2,3; cdb_tag 1,2,3 in cycles 2,3,4, then add again.
REQ-029 SHALL cover: only mul_req, tag 5, value 0x000000AB -> mul_grant same cycle; next cycle cdb_valid=1, cdb_tag=5, cdb_value=0xAB, cdb_src=1.
REQ-030 SHALL cover: add and load continuous, mul idle -> grants alternate add, load, add, load; mul never granted.
REQ-031 SHALL cover: all requesting with flush=1 for 2 cycles -> no grants, cdb_valid=0 for those following cycles, pointer unchanged, arbitration resumes at same unit.
REQ-032 SHALL cover: idle cycle after a broadcast of tag 4 -> cdb_valid=0, cdb_tag stays 4.
REQ-033 SHALL cover: rst asserted with pointer=2 and all requesting -> no grants; next cycle all outputs 0; first grant afterwards goes to add.
